// File: rtl/game_control_if.sv
// ---------------------------------------------------------------------------
// Module      : game_control_if
// Description : Bundle between the board key inputs, the game datapath and
//               the game_control sequencer.
//               slave  modport - seen by game_control
//               master modport - seen by the board/datapath side
//               Inputs to the sequencer : key_up/down/left/right/attack
//                                         idle_done, draw_map_done,
//                                         draw_link_done
//               Outputs of the sequencer: init, idle, attack, up, down,
//                                         left, right, draw_map, draw_link,
//                                         timeout_err, state_dbg[2:0]
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface game_control_if;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  logic       key_attack;
  logic       idle_done;
  logic       draw_map_done;
  logic       draw_link_done;
  logic       init;
  logic       idle;
  logic       attack;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic       draw_map;
  logic       draw_link;
  logic       timeout_err;
  logic [2:0] state_dbg;

  modport slave (
    input  key_up, key_down, key_left, key_right, key_attack,
    input  idle_done, draw_map_done, draw_link_done,
    output init, idle, attack, up, down, left, right,
    output draw_map, draw_link, timeout_err, state_dbg
  );

  modport master (
    output key_up, key_down, key_left, key_right, key_attack,
    output idle_done, draw_map_done, draw_link_done,
    input  init, idle, attack, up, down, left, right,
    input  draw_map, draw_link, timeout_err, state_dbg
  );
endinterface

`default_nettype wire

// File: rtl/game_control.sv
// ---------------------------------------------------------------------------
// Module      : game_control
// Description : Per-frame sequencer for the game datapath. Steps through
//               init, map draw, sprite draw and frame wait, then turns the
//               sampled keys into at most one single-cycle action command.
//               A watchdog aborts draws that never report done.
// Ports       : clock  - system clock
//               reset  - synchronous, active-high
//               bus_if - game_control_if.slave (keys, done handshakes,
//                        command outputs, timeout_err, state_dbg)
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module game_control #(
  parameter int ATTACK_FRAMES   = 8,
  parameter int DRAW_TIMEOUT    = 1000000,
  parameter int MAP_EVERY_FRAME = 0
) (
  input wire logic       clock,
  input wire logic       reset,
  game_control_if.slave  bus_if
);

  localparam logic [7:0]  C_ATTACK_LOAD = 8'(ATTACK_FRAMES);
  localparam logic [19:0] C_WD_LAST     = 20'(DRAW_TIMEOUT - 1);
  localparam bit          C_MAP_ALWAYS  = (MAP_EVERY_FRAME != 0);

  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_DRAW_MAP   = 3'd1,
    ST_DRAW_LINK  = 3'd2,
    ST_IDLE       = 3'd3,
    ST_DECIDE     = 3'd4,
    ST_ACT_ATTACK = 3'd5,
    ST_ACT_MOVE   = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_attack_cnt;
  logic        r_attack_armed;
  logic        r_map_dirty;
  logic [19:0] r_wd_cnt;
  logic        r_init, r_idle, r_attack, r_up, r_down, r_left, r_right;
  logic        r_draw_map, r_draw_link, r_timeout_err;

  logic        w_sel_attack;
  logic        w_sel_move;
  logic        w_wd_expire;
  logic        w_next_is_draw;
  logic        w_in_draw;

  always_comb begin
    w_sel_attack   = bus_if.key_attack && r_attack_armed && (r_attack_cnt == 8'd0);
    w_sel_move     = !w_sel_attack && (r_attack_cnt == 8'd0) &&
                     (bus_if.key_up || bus_if.key_down || bus_if.key_left || bus_if.key_right);
    w_wd_expire    = (r_wd_cnt == C_WD_LAST);
    w_in_draw      = (r_state == ST_DRAW_MAP) || (r_state == ST_DRAW_LINK);

    w_next = r_state;
    case (r_state)
      // r_init doubles as "init pulse already issued" so INIT lasts one
      // visible cycle after reset releases.
      ST_INIT:       w_next = r_init ? ST_DRAW_MAP : ST_INIT;
      ST_DRAW_MAP: begin
        if (bus_if.draw_map_done)  w_next = ST_DRAW_LINK;
        else if (w_wd_expire)      w_next = ST_IDLE;
      end
      ST_DRAW_LINK: begin
        if (bus_if.draw_link_done || w_wd_expire) w_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus_if.idle_done)      w_next = ST_DECIDE;
      end
      ST_DECIDE: begin
        if (w_sel_attack)                      w_next = ST_ACT_ATTACK;
        else if (w_sel_move)                   w_next = ST_ACT_MOVE;
        else if (C_MAP_ALWAYS || r_map_dirty)  w_next = ST_DRAW_MAP;
        else                                   w_next = ST_IDLE;
      end
      ST_ACT_ATTACK: w_next = ST_DRAW_MAP;
      ST_ACT_MOVE:   w_next = ST_DRAW_MAP;
      default:       w_next = ST_INIT;
    endcase

    w_next_is_draw = (w_next == ST_DRAW_MAP) || (w_next == ST_DRAW_LINK);
  end

  // Command outputs are registered from the next state so they line up
  // with the state register cycle by cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_INIT;
      r_init         <= 1'b0;
      r_idle         <= 1'b0;
      r_attack       <= 1'b0;
      r_up           <= 1'b0;
      r_down         <= 1'b0;
      r_left         <= 1'b0;
      r_right        <= 1'b0;
      r_draw_map     <= 1'b0;
      r_draw_link    <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_attack_cnt   <= 8'd0;
      r_attack_armed <= 1'b1;
      r_map_dirty    <= 1'b1;
      r_wd_cnt       <= 20'd0;
    end else begin
      r_state     <= w_next;
      r_init      <= (w_next == ST_INIT);
      r_draw_map  <= (w_next == ST_DRAW_MAP);
      r_draw_link <= (w_next == ST_DRAW_LINK);
      r_idle      <= (w_next == ST_IDLE);
      r_attack    <= (w_next == ST_ACT_ATTACK);
      // ACT_MOVE is only reachable from DECIDE, so the live keys are the
      // ones that selected the move; priority up > down > left > right.
      r_up        <= (w_next == ST_ACT_MOVE) && bus_if.key_up;
      r_down      <= (w_next == ST_ACT_MOVE) && !bus_if.key_up && bus_if.key_down;
      r_left      <= (w_next == ST_ACT_MOVE) && !bus_if.key_up && !bus_if.key_down &&
                     bus_if.key_left;
      r_right     <= (w_next == ST_ACT_MOVE) && !bus_if.key_up && !bus_if.key_down &&
                     !bus_if.key_left && bus_if.key_right;

      if (r_state == ST_DRAW_MAP && !bus_if.draw_map_done && w_wd_expire)
        r_timeout_err <= 1'b1;
      if (r_state == ST_DRAW_LINK && !bus_if.draw_link_done && w_wd_expire)
        r_timeout_err <= 1'b1;

      if (w_next_is_draw && (w_next != r_state))
        r_wd_cnt <= 20'd0;
      else if (w_in_draw)
        r_wd_cnt <= r_wd_cnt + 20'd1;

      // Re-arming on any released cycle makes a held key fire only once.
      if (!bus_if.key_attack)
        r_attack_armed <= 1'b1;
      else if (r_state == ST_DECIDE && w_sel_attack)
        r_attack_armed <= 1'b0;

      if (r_state == ST_DECIDE && w_sel_attack)
        r_attack_cnt <= C_ATTACK_LOAD;
      else if (r_state == ST_IDLE && bus_if.idle_done && r_attack_cnt != 8'd0)
        r_attack_cnt <= r_attack_cnt - 8'd1;

      if (r_state == ST_ACT_ATTACK || r_state == ST_ACT_MOVE)
        r_map_dirty <= 1'b1;
      else if (r_state == ST_DRAW_MAP)
        r_map_dirty <= 1'b0;
    end
  end

  assign bus_if.init        = r_init;
  assign bus_if.idle        = r_idle;
  assign bus_if.attack      = r_attack;
  assign bus_if.up          = r_up;
  assign bus_if.down        = r_down;
  assign bus_if.left        = r_left;
  assign bus_if.right       = r_right;
  assign bus_if.draw_map    = r_draw_map;
  assign bus_if.draw_link   = r_draw_link;
  assign bus_if.timeout_err = r_timeout_err;
  assign bus_if.state_dbg   = r_state;

endmodule

`default_nettype wire
